// File: rtl/sib_sync_pkg.sv
// Shared definitions for the toggle-handshake clock-domain crossing.
// Holds the source FSM encoding and the legal synchronizer depth range.
package sib_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic {
    SRC_IDLE     = 1'b0,
    SRC_WAIT_ACK = 1'b1
  } src_state_e;

endpackage

// File: rtl/sib_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// The output is the last flop of the chain.
module sib_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sib_sync_hs.sv
// Toggle-handshake CDC for one DWIDTH word at a time: req toggles into dclk,
// ack toggles back into sclk; the held word is sampled only under handshake.
module sib_sync_hs
  import sib_sync_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sclk_i,
  input  logic              srst_ni,
  input  logic              dclk_i,
  input  logic              drst_ni,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  input  logic [DWIDTH-1:0] src_data_i,
  output logic              dst_valid_o,
  input  logic              dst_ready_i,
  output logic [DWIDTH-1:0] dst_data_o,
  output src_state_e        src_state_o
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sib_sync_hs: SYNC_STAGES out of legal range");
  end

  // Handshake (both sides): a transfer happens on a clock edge where valid
  // and ready are both 1; valid holds with stable data until that edge.

  src_state_e        state;
  logic              req_t;
  logic              ack_sync;
  logic              src_ready_q;
  logic [DWIDTH-1:0] hold_q;

  always_ff @(posedge sclk_i or negedge srst_ni) begin
    if (!srst_ni) begin
      state       <= SRC_IDLE;
      req_t       <= 1'b0;
      hold_q      <= '0;
      src_ready_q <= 1'b1;
    end else begin
      case (state)
        SRC_IDLE: begin
          if (src_valid_i) begin
            hold_q      <= src_data_i;
            req_t       <= ~req_t;
            state       <= SRC_WAIT_ACK;
            src_ready_q <= 1'b0;
          end
        end
        SRC_WAIT_ACK: begin
          if (ack_sync == req_t) begin
            state       <= SRC_IDLE;
            src_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign src_ready_o = src_ready_q;
  assign src_state_o = state;

  logic              req_sync;
  logic              req_q;
  logic              ack_t;
  logic [DWIDTH-1:0] data_q;

  sib_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (dclk_i),
    .rst_n (drst_ni),
    .d     (req_t),
    .q     (req_sync)
  );

  sib_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (sclk_i),
    .rst_n (srst_ni),
    .d     (ack_t),
    .q     (ack_sync)
  );

  // req_q lags req_sync by one edge, so hold_q is captured on the same edge
  // that valid rises, and has been stable for SYNC_STAGES dclk edges by then.
  always_ff @(posedge dclk_i or negedge drst_ni) begin
    if (!drst_ni) begin
      req_q  <= 1'b0;
      ack_t  <= 1'b0;
      data_q <= '0;
    end else begin
      req_q <= req_sync;
      if ((req_sync != ack_t) && (req_q == ack_t)) begin
        data_q <= hold_q;
      end
      if (dst_valid_o && dst_ready_i) begin
        ack_t <= ~ack_t;
      end
    end
  end

  assign dst_valid_o = req_q ^ ack_t;
  assign dst_data_o  = data_q;

endmodule

// File: tb/tb_sib_sync_hs.sv
// Randomized bench for sib_sync_hs: an ordered expected-word queue models the
// one-word-per-accept contract; a second instance checks SYNC_STAGES=3 latency.
`timescale 1ns/1ps
module tb_sib_sync_hs;
  import sib_sync_pkg::*;

  // ---------------- clocks and reset ----------------
  realtime s_half = 5.0;
  realtime d_half = 13.5;
  realtime phase2;
  logic sclk = 1'b0, dclk = 1'b0, sclk2 = 1'b0, dclk2 = 1'b0;
  logic srst_n, drst_n;

  always #(s_half) sclk = ~sclk;
  always #(d_half) dclk = ~dclk;
  always #5 sclk2 = ~sclk2;
  initial begin
    phase2 = 0.5 + $urandom_range(0, 8000) / 1000.0;
    if (phase2 > 4.8 && phase2 < 5.2) phase2 = phase2 + 0.6;
    #(phase2);
    forever #5 dclk2 = ~dclk2;
  end

  // ---------------- DUTs ----------------
  logic        src_valid, src_ready, dst_valid, dst_ready;
  logic [31:0] src_data, dst_data;
  src_state_e  src_state;

  sib_sync_hs #(.DWIDTH(32), .SYNC_STAGES(2)) u_dut (
    .sclk_i      (sclk),
    .srst_ni     (srst_n),
    .dclk_i      (dclk),
    .drst_ni     (drst_n),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .src_data_i  (src_data),
    .dst_valid_o (dst_valid),
    .dst_ready_i (dst_ready),
    .dst_data_o  (dst_data),
    .src_state_o (src_state)
  );

  logic        src_valid2, src_ready2, dst_valid2, dst_ready2;
  logic [31:0] src_data2, dst_data2;
  src_state_e  src_state2;

  sib_sync_hs #(.DWIDTH(32), .SYNC_STAGES(3)) u_dut3 (
    .sclk_i      (sclk2),
    .srst_ni     (srst_n),
    .dclk_i      (dclk2),
    .drst_ni     (drst_n),
    .src_valid_i (src_valid2),
    .src_ready_o (src_ready2),
    .src_data_i  (src_data2),
    .dst_valid_o (dst_valid2),
    .dst_ready_i (dst_ready2),
    .dst_data_o  (dst_data2),
    .src_state_o (src_state2)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int consumed = 0;
  int ready_mode = 1;  // 0: hold off, 1: always ready, 2: random
  bit drop_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  always @(posedge dclk) begin
    #0.2;
    if (ready_mode == 0) dst_ready = 1'b0;
    else if (ready_mode == 1) dst_ready = 1'b1;
    else dst_ready = 1'($urandom_range(0, 1));
  end

  // A word is consumed on the posedge following a negedge that sees valid&ready.
  always @(negedge dclk) begin
    if (drop_pending) begin
      chk("valid_drop_after_consume", 32'(dst_valid), 32'd0);
      drop_pending = 1'b0;
    end
    if (srst_n && drst_n && dst_valid && dst_ready) begin
      consumed++;
      if (exp_q.size() == 0) chk("unexpected_word", 32'd0, 32'd1);
      else chk("delivered_word", dst_data, exp_q.pop_front());
      drop_pending = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    srst_n = 1'b0;
    drst_n = 1'b0;
    repeat (6) @(posedge dclk);
    repeat (6) @(posedge sclk);
    @(negedge sclk) srst_n = 1'b1;
    @(negedge dclk) drst_n = 1'b1;
    drop_pending = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    @(negedge sclk);
    while (!src_ready && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    if (!src_ready) begin
      chk("send_timeout", 32'(src_ready), 32'd1);
      return;
    end
    src_valid = 1'b1;
    src_data  = d;
    exp_q.push_back(d);
    @(negedge sclk);
    src_valid = 1'b0;
    src_data  = $urandom;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(negedge dclk);
      n++;
    end
    repeat (2) @(negedge dclk);
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c0, n;
    bit bad_v, bad_d, bad_r, ok;
    logic [31:0] d;

    src_valid = 1'b0; src_data = '0; dst_ready = 1'b0;
    src_valid2 = 1'b0; src_data2 = '0; dst_ready2 = 1'b1;
    do_reset();

    chk("rst_src_ready", 32'(src_ready), 32'd1);
    chk("rst_dst_valid", 32'(dst_valid), 32'd0);
    chk("rst_dst_data", dst_data, 32'd0);
    chk("rst_state_idle", 32'(src_state), 32'(SRC_IDLE));
    chk("rst_src_ready_ss3", 32'(src_ready2), 32'd1);

    // Ready with nothing pending does nothing.
    ready_mode = 1;
    repeat (20) @(negedge dclk);
    chk("idle_ready_no_valid", 32'(dst_valid), 32'd0);
    chk("idle_ready_no_consume", consumed, 32'd0);

    // Single word at 100/37 MHz, then ack-to-ready turnaround.
    c0 = consumed;
    send_word(32'hDEADBEEF);
    n = 0;
    while (consumed == c0 && n < 200) begin
      @(negedge dclk);
      n++;
    end
    chk("deadbeef_consumed", 32'(consumed - c0), 32'd1);
    @(posedge dclk);
    n = 0;
    while (n < 20) begin
      @(posedge sclk);
      n++;
      @(negedge sclk);
      if (src_ready) break;
    end
    chk("ack_to_ready_within_4", 32'(n >= 1 && n <= 4), 32'd1);
    repeat (10) @(negedge dclk);
    chk("deadbeef_one_pulse", 32'(consumed - c0), 32'd1);

    // Burst of 64 incrementing words, dclk 3x sclk, random ready.
    d_half = 5.0 / 3.0;
    ready_mode = 2;
    c0 = consumed;
    for (int i = 0; i < 64; i++) send_word(32'h0000_1000 + 32'(i));
    wait_drain("burst_drain");
    chk("burst_count", 32'(consumed - c0), 32'd64);

    // Word held with ready low for 50 dclk cycles.
    d_half = 13.5;
    ready_mode = 0;
    send_word(32'h0000_0055);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge dclk);
      ok = dst_valid;
    end
    chk("hold_valid_seen", 32'(ok), 32'd1);
    bad_v = 1'b0; bad_d = 1'b0; bad_r = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge dclk);
      if (dst_valid !== 1'b1) bad_v = 1'b1;
      if (dst_data !== 32'h0000_0055) bad_d = 1'b1;
      if (src_ready !== 1'b0) bad_r = 1'b1;
    end
    chk("hold_valid_stable", 32'(bad_v), 32'd0);
    chk("hold_data_stable", 32'(bad_d), 32'd0);
    chk("hold_src_not_ready", 32'(bad_r), 32'd0);
    ready_mode = 1;
    wait_drain("hold_drain");

    // Source data changes during WAIT_ACK are ignored.
    ready_mode = 0;
    c0 = consumed;
    send_word(32'h1234_5678);
    @(negedge sclk);
    src_valid = 1'b1;
    src_data  = 32'hFFFF_FFFF;
    repeat (3) @(negedge sclk);
    chk("wait_ack_not_ready", 32'(src_ready), 32'd0);
    src_valid = 1'b0;
    ready_mode = 1;
    wait_drain("wait_ack_drain");
    chk("wait_ack_one_word", 32'(consumed - c0), 32'd1);

    // Both resets mid-transfer discard the in-flight word.
    ready_mode = 0;
    send_word(32'hCAFE_F00D);
    repeat (3) @(negedge dclk);
    do_reset();
    exp_q.delete();
    @(negedge dclk);
    chk("midrst_src_ready", 32'(src_ready), 32'd1);
    chk("midrst_dst_valid", 32'(dst_valid), 32'd0);
    chk("midrst_dst_data", dst_data, 32'd0);
    ready_mode = 1;
    c0 = consumed;
    send_word(32'hA5A5_A5A5);
    wait_drain("post_reset_drain");
    chk("post_reset_one_word", 32'(consumed - c0), 32'd1);

    // SYNC_STAGES=3, equal frequencies, random phase: 4 or 5 dclk edges.
    for (int k = 0; k < 6; k++) begin
      n = 0;
      @(negedge sclk2);
      while (!src_ready2 && n < 200) begin
        @(negedge sclk2);
        n++;
      end
      chk("ss3_ready_before_send", 32'(src_ready2), 32'd1);
      d = $urandom;
      src_valid2 = 1'b1;
      src_data2  = d;
      @(posedge sclk2);
      n = 0;
      do begin
        @(posedge dclk2);
        n++;
        @(negedge dclk2);
      end while (!dst_valid2 && n < 20);
      src_valid2 = 1'b0;
      src_data2  = ~d;
      chk("ss3_latency_4_or_5", 32'(n == 4 || n == 5), 32'd1);
      chk("ss3_data", dst_data2, d);
      @(negedge dclk2);
      chk("ss3_valid_drop", 32'(dst_valid2), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sib_sync_hs.md
SIB_SYNC_HS -- requirements
Module: sib_sync_hs

Interface
REQ-001 Parameter DWIDTH, default 32, width of the transferred data word.
REQ-002 Parameter SYNC_STAGES, default 2, flops per synchronizer chain; legal range 2..4.
REQ-003 sclk_i  input  1  source clock.
REQ-004 srst_ni  input  1  source reset, asynchronous, active-low.
REQ-005 dclk_i  input  1  destination clock, asynchronous to sclk_i.
REQ-006 drst_ni  input  1  destination reset, asynchronous, active-low.
REQ-007 src_valid_i  input  1  source offers a word.
REQ-008 src_ready_o  output  1  source side can accept a word.
REQ-009 src_data_i  input  DWIDTH  source word.
REQ-010 dst_valid_o  output  1  word available in the destination domain.
REQ-011 dst_ready_i  input  1  destination consumes the word.
REQ-012 dst_data_o  output  DWIDTH  delivered word.

Function
REQ-013 The block SHALL implement a full four-phase-equivalent toggle handshake: source req_t toggle, destination ack_t toggle, each synchronized into the other domain via SYNC_STAGES flops.
REQ-014 Source FSM states SHALL be IDLE and WAIT_ACK; src_ready_o SHALL be 1 only in IDLE.
REQ-015 In IDLE with src_valid_i=1 at a sclk_i edge, the block SHALL load src_data_i into hold_q, toggle req_t, and enter WAIT_ACK.
REQ-016 hold_q SHALL remain stable throughout WAIT_ACK; src_data_i changes in that state SHALL be ignored.
REQ-017 WAIT_ACK SHALL return to IDLE on the first sclk_i edge where synchronized ack equals req_t.
REQ-018 dst_valid_o SHALL be (synchronized req != ack_t), registered signals only, with no combinational path from any sclk_i-domain signal.
REQ-019 dst_data_o SHALL be driven from a dclk_i register loaded from hold_q on the dclk_i edge where synchronized req first differs from ack_t; the word is therefore valid in the same cycle dst_valid_o rises.
REQ-020 On a dclk_i edge with dst_valid_o=1 and dst_ready_i=1, ack_t SHALL toggle, and dst_valid_o SHALL be 0 in the following cycle.
REQ-021 dst_valid_o SHALL hold, with dst_data_o unchanged, for any number of cycles while dst_ready_i=0.
REQ-022 Latency from source accept to dst_valid_o SHALL be SYNC_STAGES+1 dclk_i edges (±1 for synchronizer sampling).
REQ-023 Latency from destination consume to src_ready_o=1 SHALL be SYNC_STAGES+1 sclk_i edges (±1 for synchronizer sampling).
REQ-024 Exactly one word SHALL be delivered per accepted word, with no loss or duplication, for any sclk_i/dclk_i ratio.
REQ-025 dst_ready_i asserted while dst_valid_o=0 SHALL have no effect.

Reset
REQ-026 srst_ni low SHALL clear req_t, hold_q and the source-side ack synchronizer, and force the FSM to IDLE, so src_ready_o=1 after reset.
REQ-027 drst_ni low SHALL clear ack_t, dst_data_o and the destination-side req synchronizer, so dst_valid_o=0.
REQ-028 Both resets SHALL be asserted with overlap of at least SYNC_STAGES+1 cycles of the slower clock; a reset in either domain mid-transfer discards the in-flight word.
REQ-029 Single-domain reset is outside the supported operating range.

Structure
REQ-030 FSM state encoding and the SYNC_STAGES legal-range bounds SHALL live in a shared package sib_sync_pkg.
REQ-031 One sub-module, sib_sync_bit (parameter STAGES, async active-low reset), SHALL be instantiated twice: once for req into dclk_i and once for ack into sclk_i.
REQ-032 Multi-bit hold_q SHALL cross domains only under handshake control, never through a synchronizer.

Verification
REQ-033 sclk 100 MHz, dclk 37 MHz, DWIDTH=32: send 0xDEADBEEF with dst_ready_i=1 -> dst_data_o=0xDEADBEEF, one dst_valid_o pulse, src_ready_o back to 1 within 4 sclk_i edges of ack toggle.
REQ-034 Burst of 64 incrementing words, dclk 3x faster than sclk, with random dst_ready_i -> 64 words in order, none missing or duplicated.
REQ-035 dst_ready_i held 0 for 50 dclk cycles with word 0x00000055 pending -> dst_valid_o=1 and dst_data_o stable throughout; src_ready_o=0 throughout.
REQ-036 src_data_i changed to 0xFFFFFFFF during WAIT_ACK after accepting 0x12345678 -> 0x12345678 delivered.
REQ-037 Both resets asserted mid-transfer -> src_ready_o=1, dst_valid_o=0, dst_data_o=0; the next word 0xA5A5A5A5 is delivered correctly.
REQ-038 SYNC_STAGES=3 with sclk=dclk frequency at a random phase -> accept-to-dst_valid_o latency of 4 or 5 dclk_i edges.
